// File: rtl/pc_redirect_ctrl.sv
// Fetch PC register and redirect sequencer for the RV32I pipeline.
// Optional redirect counter is built when REDIRECT_CNT_EN is defined.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic        StallF,
  input  logic        BranchE,
  input  logic [31:0] BranchTarget,
  input  logic        JalrE,
  input  logic [31:0] JalrTarget,
  input  logic        JalD,
  input  logic [31:0] JalTarget,
  output logic [31:0] PCF,
  output logic        FlushD,
  output logic        FlushE,
  output logic        RedirectPending,
  output logic [31:0] RedirectCnt
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pend_tgt;
  logic        pend_ex;

  logic        ex_src;
  logic        any_src;
  logic [31:0] sel_tgt;
  logic [31:0] tgt;

  // Handshake-free control: every source is a one-cycle level; StallF is a
  // hold request from the hazard unit, sampled on each rising edge.
  always_comb begin
    ex_src  = BranchE | JalrE;
    any_src = ex_src | JalD;
    sel_tgt = JalTarget;
    if (BranchE)
      sel_tgt = BranchTarget;
    else if (JalrE)
      sel_tgt = JalrTarget;
    tgt = sel_tgt & 32'hFFFF_FFFC;
  end

  assign FlushD = ~CPU_RST & any_src;
  assign FlushE = ~CPU_RST & ex_src;

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      state           <= RUN;
      PCF             <= RESET_PC;
      pend_tgt        <= 32'h0;
      pend_ex         <= 1'b0;
      RedirectPending <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!StallF) begin
            PCF <= any_src ? tgt : PCF + 32'd4;
          end else if (any_src) begin
            pend_tgt        <= tgt;
            pend_ex         <= ex_src;
            state           <= HOLD;
            RedirectPending <= 1'b1;
          end
        end
        HOLD: begin
          if (StallF) begin
            // An ID-stage jal never displaces a buffered EX redirect: it is wrong-path.
            if (ex_src || (JalD && !pend_ex)) begin
              pend_tgt <= tgt;
              pend_ex  <= ex_src;
            end
          end else begin
            PCF             <= ex_src ? tgt : pend_tgt;
            pend_tgt        <= 32'h0;
            pend_ex         <= 1'b0;
            state           <= RUN;
            RedirectPending <= 1'b0;
          end
        end
        default: begin
          state           <= RUN;
          RedirectPending <= 1'b0;
        end
      endcase
    end
  end

`ifdef REDIRECT_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST)
      cnt_q <= 32'h0;
    else if (FlushD)
      cnt_q <= cnt_q + 32'd1;
  end

  assign RedirectCnt = cnt_q;
`else
  assign RedirectCnt = 32'h0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios followed by randomized
// stimulus, all checked against a behavioural model of the redirect rules.
module tb_pc_redirect_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        CPU_CLK;
  logic        CPU_RST;
  logic        StallF;
  logic        BranchE;
  logic [31:0] BranchTarget;
  logic        JalrE;
  logic [31:0] JalrTarget;
  logic        JalD;
  logic [31:0] JalTarget;
  logic [31:0] PCF;
  logic        FlushD;
  logic        FlushE;
  logic        RedirectPending;
  logic [31:0] RedirectCnt;

  pc_redirect_ctrl #(.RESET_PC(RST_PC)) dut (
    .CPU_CLK         (CPU_CLK),
    .CPU_RST         (CPU_RST),
    .StallF          (StallF),
    .BranchE         (BranchE),
    .BranchTarget    (BranchTarget),
    .JalrE           (JalrE),
    .JalrTarget      (JalrTarget),
    .JalD            (JalD),
    .JalTarget       (JalTarget),
    .PCF             (PCF),
    .FlushD          (FlushD),
    .FlushE          (FlushE),
    .RedirectPending (RedirectPending),
    .RedirectCnt     (RedirectCnt)
  );

  // clock / reset
  initial CPU_CLK = 1'b0;
  always #5 CPU_CLK = ~CPU_CLK;

  int n_vec = 0;
  int n_err = 0;

  // reference model state: the PC, whether a redirect is buffered, its
  // target, and whether it came from the EX stage
  logic [31:0] m_pc = RST_PC;
  logic        m_hold = 1'b0;
  logic [31:0] m_ptgt = 32'h0;
  logic        m_pex = 1'b0;
  logic [31:0] m_cnt = 32'h0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver: applies one cycle of inputs, checks combinational flushes,
  // advances the model at the edge and checks the registered outputs
  task automatic step(input logic rst, input logic stall,
                      input logic b, input logic [31:0] bt,
                      input logic jr, input logic [31:0] jt,
                      input logic jd, input logic [31:0] jdt);
    logic        ex;
    logic        any;
    logic [31:0] t;
    logic [31:0] exp_cnt;
    CPU_RST = rst; StallF = stall;
    BranchE = b; BranchTarget = bt;
    JalrE = jr;  JalrTarget = jt;
    JalD = jd;   JalTarget = jdt;
    ex  = b | jr;
    any = ex | jd;
    t   = b ? bt : (jr ? jt : jdt);
    t   = {t[31:2], 2'b00};
    #1;
    check("flushd", {31'h0, FlushD}, {31'h0, !rst && any});
    check("flushe", {31'h0, FlushE}, {31'h0, !rst && ex});
    @(posedge CPU_CLK);
    if (rst) begin
      m_pc = RST_PC; m_hold = 1'b0; m_ptgt = 32'h0; m_pex = 1'b0; m_cnt = 32'h0;
    end else begin
      if (any) m_cnt = m_cnt + 32'd1;
      if (!m_hold) begin
        if (!stall) m_pc = any ? t : m_pc + 32'd4;
        else if (any) begin m_hold = 1'b1; m_ptgt = t; m_pex = ex; end
      end else if (stall) begin
        if (ex || (jd && !m_pex)) begin m_ptgt = t; m_pex = ex; end
      end else begin
        m_pc = ex ? t : m_ptgt;
        m_hold = 1'b0;
      end
    end
    exp_q.push_back(m_pc);
    #1;
    check("pcf", PCF, exp_q.pop_front());
    check("pending", {31'h0, RedirectPending}, {31'h0, m_hold});
`ifdef REDIRECT_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 32'h0;
`endif
    check("cnt", RedirectCnt, exp_cnt);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    // reset and sequential fetch
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("reset_pc", PCF, 32'h100);
    check("reset_pending", {31'h0, RedirectPending}, 32'h0);
    idle(); check("seq_104", PCF, 32'h104);
    idle(); check("seq_108", PCF, 32'h108);
    idle(); check("seq_10c", PCF, 32'h10C);

    // branch beats a simultaneous jal, target aligned
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h200);
    check("jal_200", PCF, 32'h200);
    step(1'b0, 1'b0, 1'b1, 32'h403, 1'b0, 32'h0, 1'b1, 32'h999);
    check("branch_400", PCF, 32'h400);

    // redirect buffered under stall, EX overwrites ID-class pending
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h300);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h500);
    check("hold_pc_300", PCF, 32'h300);
    check("hold_pending", {31'h0, RedirectPending}, 32'h1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h600, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hA00);
    idle();
    check("release_600", PCF, 32'h600);
    check("release_pending", {31'h0, RedirectPending}, 32'h0);

    // new EX source on the release cycle wins over pending
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h500);
    step(1'b0, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 32'h0);
    check("release_700", PCF, 32'h700);

    // wrap at the top of the address space
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    check("wrap_0", PCF, 32'h0);

    // reset discards a buffered redirect
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h800);
    step(1'b1, 1'b1, 1'b1, 32'h900, 1'b0, 32'h0, 1'b0, 32'h0);
    check("rst_hold_pc", PCF, 32'h100);
    check("rst_hold_pending", {31'h0, RedirectPending}, 32'h0);
    idle();
    check("rst_seq_104", PCF, 32'h104);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0, $urandom,
           $urandom_range(0, 7) == 0, $urandom,
           $urandom_range(0, 5) == 0, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
